mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port synchronous-read memory between two requesters:
//  port 0 = instruction fetch (read-only), port 1 = data load/store.
//  Round-robin arbitration; valid/grant request handshake; one-cycle read response.
//  Sits between the fetch/data stages and a single memory instance.
// PARAMETERS
//  DATAWIDTH  32  word width
//  NUMWORDS   32  memory depth; ADDRWIDTH = $clog2(NUMWORDS)
// PORTS
//  clk_i        in   1          clock (single domain)
//  rst_i        in   1          reset, asynchronous, active-high
//  p0_req_i     in   1          fetch read request
//  p0_addr_i    in   ADDRWIDTH  fetch word address
//  p0_gnt_o     out  1          fetch request accepted this cycle
//  p0_rvalid_o  out  1          fetch read data valid
//  p0_rdata_o   out  DATAWIDTH  fetch read data
//  p1_req_i     in   1          data request
//  p1_we_i      in   1          1 = store, 0 = load
//  p1_addr_i    in   ADDRWIDTH  data word address
//  p1_wdata_i   in   DATAWIDTH  store data
//  p1_gnt_o     out  1          data request accepted this cycle
//  p1_rvalid_o  out  1          load data valid
//  p1_rdata_o   out  DATAWIDTH  load data
//  mem_re_o     out  1          memory read enable
//  mem_we_o     out  1          memory write enable
//  mem_addr_o   out  ADDRWIDTH  memory address (shared by read and write)
//  mem_wdata_o  out  DATAWIDTH  memory write data
//  mem_rdata_i  in   DATAWIDTH  memory read data, valid 1 cycle after mem_re_o
// BEHAVIOUR
//  - Reset (async): state=IDLE, last_gnt=1 (port 0 wins first tie), rvalid_o=0,
//    gnt_o=0, mem_re_o/mem_we_o=0, rdata_o=0.
//  - Requester holds req/addr/we/wdata stable until gnt_o; gnt_o high 1 cycle per accept.
//  - gnt_o, mem_re_o, mem_we_o, mem_addr_o, mem_wdata_o are combinational from
//    req_i, last_gnt, ~rst_i. At most one gnt_o per cycle.
//  - Arbitration: one requester -> it wins. Both -> the port != last_gnt wins.
//    last_gnt updates on every grant. Bound: a waiting request granted within 2 grants.
//  - Read grant: mem_re_o=1 same cycle; next cycle owner's rvalid_o=1,
//    rdata_o=mem_rdata_i. Non-owner rdata_o=0, rvalid_o=0.
//  - Write grant (p1, we=1): mem_we_o=1 same cycle; write is complete; no rvalid.
//  - FSM: IDLE -> RD_WAIT on read grant. RD_WAIT: asserts owner rvalid;
//    new read grant -> RD_WAIT (new owner); write grant or none -> IDLE.
//    Grants are legal in RD_WAIT (back-to-back: 1 access per cycle).
//  - Owner register (1 bit) captured at read grant; steers rvalid/rdata.
//  - Same-cycle rvalid to port X and new grant to port X is legal.
//  - Reset mid-read: pending response dropped; no rvalid after reset release.
//  - Address out of range impossible by width; no wrap handling needed.
//  - mem_addr_o/mem_wdata_o = 0 when no grant (no X propagation).
// STRUCTURE
//  - Package mem_arb_pkg: typedef enum logic {IDLE, RD_WAIT} arb_state_t;
//    localparams PORT_FETCH=1'b0, PORT_DATA=1'b1.
//  - Sub-module rr_arbiter2: req[1:0], last_gnt -> one-hot gnt[1:0] (combinational);
//    last_gnt flop in mem_arbiter.
// TESTING
//  1. Reset with p0_req=1, p1_req=1 held -> all outputs 0 until rst_i drops;
//     first grant to p0.
//  2. p0 reads addr 3 (mem[3]=0xDEADBEEF) -> p0_gnt cycle N, p0_rvalid and
//     p0_rdata=0xDEADBEEF cycle N+1, p1_rvalid=0.
//  3. p0 and p1 both request continuously for 6 cycles -> grants alternate
//     p0,p1,p0,p1,p0,p1; one grant per cycle.
//  4. p1 store 0x12345678 to addr 7, then p0 reads addr 7 -> mem_we_o 1 cycle,
//     no p1_rvalid, p0_rdata=0x12345678.
//  5. p1 load addr 5 granted, rst_i asserted next cycle before rvalid edge ->
//     p1_rvalid stays 0; FSM IDLE after reset.
//  6. p0 back-to-back reads addr 1,2 with p1 idle -> grants consecutive cycles,
//     rvalid 2 consecutive cycles, data in order.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Port 0 is instruction fetch and port 1 is data load/store.
package mem_arb_pkg;

  typedef enum logic {
    IDLE,
    RD_WAIT
  } arb_state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter producing a one-hot grant.
// The last_gnt history flop lives in the parent so this block stays purely combinational.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_gnt == PORT_DATA) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous-read memory between fetch (port 0) and data (port 1).
// Grants and memory strobes are combinational; read responses return one cycle after the grant.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int NUMWORDS  = 32,
  localparam int ADDRWIDTH = $clog2(NUMWORDS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 p0_req_i,
  input  logic [ADDRWIDTH-1:0] p0_addr_i,
  output logic                 p0_gnt_o,
  output logic                 p0_rvalid_o,
  output logic [DATAWIDTH-1:0] p0_rdata_o,
  input  logic                 p1_req_i,
  input  logic                 p1_we_i,
  input  logic [ADDRWIDTH-1:0] p1_addr_i,
  input  logic [DATAWIDTH-1:0] p1_wdata_i,
  output logic                 p1_gnt_o,
  output logic                 p1_rvalid_o,
  output logic [DATAWIDTH-1:0] p1_rdata_o,
  output logic                 mem_re_o,
  output logic                 mem_we_o,
  output logic [ADDRWIDTH-1:0] mem_addr_o,
  output logic [DATAWIDTH-1:0] mem_wdata_o,
  input  logic [DATAWIDTH-1:0] mem_rdata_i
);

  arb_state_t state;
  logic       last_gnt;
  logic       owner;
  logic [1:0] arb_gnt;
  logic [1:0] gnt;
  logic       read_gnt;
  logic       write_gnt;

  rr_arbiter2 u_rr_arbiter2 (
    .req      ({p1_req_i, p0_req_i}),
    .last_gnt (last_gnt),
    .gnt      (arb_gnt)
  );

  // Grants are suppressed while reset is held so nothing reaches the memory.
  assign gnt       = arb_gnt & {2{~rst_i}};
  assign read_gnt  = gnt[0] | (gnt[1] & ~p1_we_i);
  assign write_gnt = gnt[1] & p1_we_i;

  assign p0_gnt_o    = gnt[0];
  assign p1_gnt_o    = gnt[1];
  assign mem_re_o    = read_gnt;
  assign mem_we_o    = write_gnt;
  assign mem_wdata_o = write_gnt ? p1_wdata_i : '0;

  always_comb begin
    mem_addr_o = '0;
    if (gnt[0]) begin
      mem_addr_o = p0_addr_i;
    end else if (gnt[1]) begin
      mem_addr_o = p1_addr_i;
    end
  end

  // Memory data only appears during the response cycle, so rdata is steered rather than stored.
  assign p0_rdata_o = (state == RD_WAIT && owner == PORT_FETCH) ? mem_rdata_i : '0;
  assign p1_rdata_o = (state == RD_WAIT && owner == PORT_DATA)  ? mem_rdata_i : '0;

  // Every read grant opens a response cycle; writes and idle cycles close it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      last_gnt    <= PORT_DATA;
      owner       <= PORT_FETCH;
      p0_rvalid_o <= 1'b0;
      p1_rvalid_o <= 1'b0;
    end else begin
      if (|gnt) begin
        last_gnt <= gnt[1];
      end
      if (read_gnt) begin
        state       <= RD_WAIT;
        owner       <= gnt[1];
        p0_rvalid_o <= gnt[0];
        p1_rvalid_o <= gnt[1];
      end else begin
        state       <= IDLE;
        p0_rvalid_o <= 1'b0;
        p1_rvalid_o <= 1'b0;
      end
    end
  end

endmodule
